reg_writeback: RTL and testbench

Write-back stage that sits directly upstream of the register file and owns its single write port (reg_write_en / reg_write_dest / reg_write_data).
- Merges single-cycle ALU results with load results from memory.
- Buffers load results in a small FIFO.
- Keeps a per-register pending-load scoreboard so decode can detect read-after-load hazards.

---
 rtl/reg_writeback.sv | 154 +++++++++++++++
 tb/tb_reg_writeback.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register-file write-back stage with load FIFO and pending-load scoreboard; WB_BYPASS_EN adds forwarding ports
module reg_writeback #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_dest,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   pend_set,
    input  logic [ADDR_W-1:0]      pend_dest,
    input  logic [ADDR_W-1:0]      read_addr_1,
    input  logic [ADDR_W-1:0]      read_addr_2,
    output logic                   hazard_1,
    output logic                   hazard_2,
    output logic [(1<<ADDR_W)-1:0] busy,
`ifdef WB_BYPASS_EN
    output logic                   byp_hit_1,
    output logic                   byp_hit_2,
    output logic [DATA_W-1:0]      byp_data_1,
    output logic [DATA_W-1:0]      byp_data_2,
`endif
    output logic                   reg_write_en,
    output logic [ADDR_W-1:0]      reg_write_dest,
    output logic [DATA_W-1:0]      reg_write_data
);

    localparam int                NREG     = 1 << ADDR_W;
    localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    logic [ADDR_W-1:0] fifo_dest_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              wen_q, wen_d;
    logic              from_mem_q, from_mem_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic push;
    logic pop;
    logic alu_take;

    // mem_ready looks only at the registered count so it never depends on this cycle's pop
    always_comb begin
        mem_ready = rst && (count_q != FULL_CNT);
        push      = mem_valid && mem_ready && (mem_dest != ZERO_REG);
        alu_take  = alu_valid && (alu_dest != ZERO_REG);
        pop       = !alu_take && (count_q != '0);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ALU has strict priority; an idle port keeps its last dest/data
    always_comb begin
        wen_d      = 1'b0;
        from_mem_d = 1'b0;
        dest_d     = dest_q;
        data_d     = data_q;
        if (alu_take) begin
            wen_d  = 1'b1;
            dest_d = alu_dest;
            data_d = alu_data;
        end else if (pop) begin
            wen_d      = 1'b1;
            from_mem_d = 1'b1;
            dest_d     = fifo_dest_q[rd_ptr_q];
            data_d     = fifo_data_q[rd_ptr_q];
        end
    end

    // Clear is applied first so a same-edge set on that register wins
    always_comb begin
        busy_d = busy_q;
        if (wen_q && from_mem_q) begin
            busy_d[dest_q] = 1'b0;
        end
        if (pend_set && (pend_dest != ZERO_REG)) begin
            busy_d[pend_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            wen_q      <= 1'b0;
            from_mem_q <= 1'b0;
            dest_q     <= '0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            wen_q      <= wen_d;
            from_mem_q <= from_mem_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
        end
    end

    // Storage needs no reset: count and pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest_q[wr_ptr_q] <= mem_dest;
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

    assign busy           = busy_q;
    assign reg_write_en   = wen_q;
    assign reg_write_dest = dest_q;
    assign reg_write_data = data_q;

`ifdef WB_BYPASS_EN
    always_comb begin
        byp_hit_1  = wen_q && (dest_q == read_addr_1) && (read_addr_1 != ZERO_REG);
        byp_hit_2  = wen_q && (dest_q == read_addr_2) && (read_addr_2 != ZERO_REG);
        byp_data_1 = data_q;
        byp_data_2 = data_q;
        hazard_1   = busy_q[read_addr_1] && !(byp_hit_1 && from_mem_q);
        hazard_2   = busy_q[read_addr_2] && !(byp_hit_2 && from_mem_q);
    end
`else
    always_comb begin
        hazard_1 = busy_q[read_addr_1];
        hazard_2 = busy_q[read_addr_2];
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - scoreboard bench for reg_writeback
module tb_reg_writeback;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_dest;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic [AW-1:0] mem_dest;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          pend_set;
    logic [AW-1:0] pend_dest;
    logic [AW-1:0] read_addr_1;
    logic [AW-1:0] read_addr_2;
    logic          hazard_1;
    logic          hazard_2;
    logic [(1<<AW)-1:0] busy;
    logic          reg_write_en;
    logic [AW-1:0] reg_write_dest;
    logic [DW-1:0] reg_write_data;

    typedef struct packed {
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    logic [AW-1:0] ld_dest [4] = '{4'd1, 4'd2, 4'd4, 4'd6};

    always #5 clk = ~clk;

    reg_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_dest       (mem_dest),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .pend_set       (pend_set),
        .pend_dest      (pend_dest),
        .read_addr_1    (read_addr_1),
        .read_addr_2    (read_addr_2),
        .hazard_1       (hazard_1),
        .hazard_2       (hazard_2),
        .busy           (busy),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data)
    );

    // Every write seen on the port must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (rst === 1'b1 && reg_write_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_write: got dest=%0d data=%02h, required no write",
                         reg_write_dest, reg_write_data);
            end else begin
                e = exp_q.pop_front();
                if ({reg_write_dest, reg_write_data} !== e) begin
                    n_mis++;
                    $display("FAIL write_port: got dest=%0d data=%02h, required dest=%0d data=%02h",
                             reg_write_dest, reg_write_data, e.dest, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d writes still outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        mem_valid = 1'b0; mem_dest = '0; mem_data = '0;
        pend_set = 1'b0; pend_dest = '0; read_addr_1 = '0; read_addr_2 = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== '0) begin
            n_mis++;
            $display("FAIL reset_write_port: got en=%b dest=%0d data=%02h, required all 0",
                     reg_write_en, reg_write_dest, reg_write_data);
        end
        n_cmp++;
        if (busy !== '0) begin n_mis++; $display("FAIL reset_busy: got %h, required 0", busy); end
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_mis++; $display("FAIL reset_mem_ready: got %b, required 0", mem_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_mis++; $display("FAIL post_reset_mem_ready: got %b, required 1", mem_ready); end
    endtask

    task automatic test_alu_write();
        tick();
        alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 8'h07;
        exp_q.push_back('{dest: 4'd3, data: 8'h07});
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (reg_write_en !== 1'b1) begin n_mis++; $display("FAIL alu_latency: got en=%b, required 1", reg_write_en); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (reg_write_en !== 1'b0) begin n_mis++; $display("FAIL alu_single_write: got en=%b, required 0", reg_write_en); end
    endtask

    task automatic test_load_pending();
        tick();
        pend_set = 1'b1; pend_dest = 4'd5;
        tick();
        pend_set = 1'b0;
        read_addr_1 = 4'd5; read_addr_2 = 4'd5;
        #1;
        n_cmp++;
        if ({busy[5], hazard_1, hazard_2} !== 3'b111) begin
            n_mis++;
            $display("FAIL pend_set: got busy5=%b haz1=%b haz2=%b, required 1 1 1", busy[5], hazard_1, hazard_2);
        end
        mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 8'h2A;
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_mis++; $display("FAIL load_ready: got %b, required 1", mem_ready); end
        exp_q.push_back('{dest: 4'd5, data: 8'h2A});
        tick();
        mem_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (reg_write_en !== 1'b0) begin n_mis++; $display("FAIL load_too_early: got en=%b, required 0", reg_write_en); end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({reg_write_en, busy[5]} !== 2'b11) begin
            n_mis++;
            $display("FAIL load_write: got en=%b busy5=%b, required 1 1", reg_write_en, busy[5]);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({busy[5], hazard_1} !== 2'b00) begin
            n_mis++;
            $display("FAIL load_clear: got busy5=%b haz1=%b, required 0 0", busy[5], hazard_1);
        end
        read_addr_1 = '0; read_addr_2 = '0;
    endtask

    task automatic test_fifo_full();
        tick();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_dest = 4'd9; alu_data = 8'(8'h90 + i);
            exp_q.push_back('{dest: 4'd9, data: 8'(8'h90 + i)});
            mem_valid = 1'b1; mem_dest = ld_dest[i]; mem_data = 8'(8'hA0 + ld_dest[i]);
            n_cmp++;
            if (mem_ready !== 1'b1) begin n_mis++; $display("FAIL fill_ready_%0d: got %b, required 1", i, mem_ready); end
            tick();
        end
        mem_valid = 1'b0;
        alu_data = 8'h94;
        exp_q.push_back('{dest: 4'd9, data: 8'h94});
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_mis++; $display("FAIL full_ready: got %b, required 0", mem_ready); end
        tick();
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_mis++; $display("FAIL starved_ready: got %b, required 0", mem_ready); end
        alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{dest: ld_dest[i], data: 8'(8'hA0 + ld_dest[i])});
        tick();
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_mis++; $display("FAIL ready_after_pop: got %b, required 1", mem_ready); end
        wait_drain();
    endtask

    task automatic test_reg_zero();
        tick();
        alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 8'h55;
        mem_valid = 1'b1; mem_dest = 4'd0; mem_data = 8'h66;
        pend_set = 1'b1; pend_dest = 4'd0;
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_mis++; $display("FAIL zero_handshake: got ready=%b, required 1", mem_ready); end
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0; pend_set = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (reg_write_en !== 1'b0) begin n_mis++; $display("FAIL zero_write_%0d: got en=%b, required 0", i, reg_write_en); end
            tick();
        end
        n_cmp++;
        if ({mem_ready, busy} !== {1'b1, 16'h0000}) begin
            n_mis++;
            $display("FAIL zero_state: got ready=%b busy=%h, required 1 0000", mem_ready, busy);
        end
    endtask

    task automatic test_set_clear_same_edge();
        pend_set = 1'b1; pend_dest = 4'd4;
        tick();
        pend_set = 1'b0;
        mem_valid = 1'b1; mem_dest = 4'd4; mem_data = 8'h44;
        exp_q.push_back('{dest: 4'd4, data: 8'h44});
        tick();
        mem_valid = 1'b0;
        tick();
        pend_set = 1'b1; pend_dest = 4'd4;
        n_cmp++;
        if ({reg_write_en, busy[4]} !== 2'b11) begin
            n_mis++;
            $display("FAIL collide_setup: got en=%b busy4=%b, required 1 1", reg_write_en, busy[4]);
        end
        tick();
        pend_set = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy[4] !== 1'b1) begin n_mis++; $display("FAIL set_wins: got busy4=%b, required 1", busy[4]); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (busy[4] !== 1'b1) begin n_mis++; $display("FAIL set_holds: got busy4=%b, required 1", busy[4]); end
    endtask

    task automatic test_reset_mid_drain();
        tick();
        pend_set = 1'b1; pend_dest = 4'd13;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_dest = 4'd8; alu_data = 8'(8'h80 + i);
            exp_q.push_back('{dest: 4'd8, data: 8'(8'h80 + i)});
            mem_valid = 1'b1; mem_dest = 4'(10 + i); mem_data = 8'(8'hC0 + i);
            tick();
            pend_set = 1'b0;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        exp_q.push_back('{dest: 4'd10, data: 8'hC0});
        tick();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({reg_write_en, reg_write_dest, reg_write_data} !== '0) begin
            n_mis++;
            $display("FAIL async_reset_port: got en=%b dest=%0d data=%02h, required all 0",
                     reg_write_en, reg_write_dest, reg_write_data);
        end
        n_cmp++;
        if ({mem_ready, busy} !== 17'h0) begin
            n_mis++;
            $display("FAIL async_reset_state: got ready=%b busy=%h, required 0 0000", mem_ready, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (reg_write_en !== 1'b0) begin n_mis++; $display("FAIL post_reset_write_%0d: got en=%b, required 0", i, reg_write_en); end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_mis++; $display("FAIL scoreboard_left: %0d outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_pending();
        test_fifo_full();
        test_reg_zero();
        test_set_clear_same_edge();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
